serial_alu: RTL and testbench

- Bit-serial counterpart of the 32-bit ripple ALU: the same ALU_ctl encoding and the same result, zero and overflow semantics.
- Processes one bit per clock through a single 1-bit slice, least significant bit first, with a carry register.
- Uses a start/done handshake and is intended for area-constrained datapaths where a multi-cycle operation is acceptable.
- Operands are captured on start; outputs update only on completion.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/serial_bit_slice.sv | 44 ++++
 rtl/serial_alu.sv | 153 +++++++++++++++
 tb/tb_serial_alu.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: opcodes, slice operation
// selects, FSM state encoding and an opcode validity helper.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Slice output select, taken from ALU_ctl[1:0]
    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    // True for the six defined operations; anything else completes with 0
    function automatic logic is_valid_op(input logic [3:0] ctl);
        return (ctl == ALU_AND) || (ctl == ALU_OR)  || (ctl == ALU_ADD) ||
               (ctl == ALU_SUB) || (ctl == ALU_SLT) || (ctl == ALU_NOR);
    endfunction

endpackage

// File: rtl/serial_bit_slice.sv
// Combinational 1-bit ALU slice.
// Ports: a, b        - operand bits
//        a_invert    - invert a before the logic/adder
//        b_invert    - invert b before the logic/adder
//        carry_in    - adder carry in
//        operation   - 00 AND, 01 OR, 10 sum, 11 less (tied to 0)
//        result      - selected output bit
//        sum         - raw adder sum bit (needed for the SLT set bit)
//        carry_out   - adder carry out
module serial_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       carry_in,
    input  logic [1:0] operation,
    output logic       result,
    output logic       sum,
    output logic       carry_out
);

    logic a_eff;
    logic b_eff;

    assign a_eff     = a ^ a_invert;
    assign b_eff     = b ^ b_invert;
    assign sum       = a_eff ^ b_eff ^ carry_in;
    assign carry_out = (a_eff & b_eff) | (a_eff & carry_in) | (b_eff & carry_in);

    // The less input is always 0 here; the SLT bit is inserted after the last bit
    always_comb begin
        result = 1'b0;
        case (operation)
            OP_AND:  result = a_eff & b_eff;
            OP_OR:   result = a_eff | b_eff;
            OP_SUM:  result = sum;
            OP_LESS: result = 1'b0;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: one bit per clock, LSB first, through a single 1-bit slice.
// Ports: clk, rst (async, active-high)
//        start   - begin an operation (sampled only when idle)
//        a, b    - operands, captured when start is accepted
//        ALU_ctl - opcode, captured when start is accepted
//        busy    - operation in progress
//        done    - one-cycle pulse when result/zero/overflow are updated
//        result, zero, overflow - outputs of the last completed operation
module serial_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALU_ctl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [3:0]       ctl_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             msb_cin;
    logic             msb_cout;
    logic             msb_sum;

    logic             s_res;
    logic             s_sum;
    logic             s_cout;
    logic             last_bit;

    logic [WIDTH-1:0] fin_result_c;
    logic             fin_ov_c;
    logic             slt_set;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    serial_bit_slice u_slice (
        .a         (a_sh[0]),
        .b         (b_sh[0]),
        .a_invert  (ctl_q[3]),
        .b_invert  (ctl_q[2]),
        .carry_in  (carry),
        .operation (ctl_q[1:0]),
        .result    (s_res),
        .sum       (s_sum),
        .carry_out (s_cout)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Final result/overflow; set = sign of the true difference for SLT
    always_comb begin
        fin_result_c = '0;
        fin_ov_c     = 1'b0;
        slt_set      = msb_sum ^ (msb_cin ^ msb_cout);
        if (ctl_q == ALU_SLT) begin
            fin_result_c = {{(WIDTH-1){1'b0}}, slt_set};
        end else if (is_valid_op(ctl_q)) begin
            fin_result_c = res_sh;
        end
        if ((ctl_q == ALU_ADD) || (ctl_q == ALU_SUB)) begin
            fin_ov_c = msb_cin ^ msb_cout;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            ctl_q    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            msb_cin  <= 1'b0;
            msb_cout <= 1'b0;
            msb_sum  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        ctl_q <= ALU_ctl;
                        carry <= (ALU_ctl == ALU_SUB) || (ALU_ctl == ALU_SLT);
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {s_res, res_sh[WIDTH-1:1]};
                    carry  <= s_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        msb_cin  <= carry;
                        msb_cout <= s_cout;
                        msb_sum  <= s_sum;
                    end
                end
                FIN: begin
                    result   <= fin_result_c;
                    zero     <= (fin_result_c == '0);
                    overflow <= fin_ov_c;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Directed self-checking bench for serial_alu (WIDTH=32).
module tb_serial_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ALU_ctl;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    serial_alu #(.WIDTH(32), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .ALU_ctl  (ALU_ctl),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present an operation and let it be accepted at the next edge, then
    // scramble the inputs to show they are no longer used.
    task automatic start_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        ALU_ctl = c;
        a       = x;
        b       = y;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        a       = ~x;
        b       = ~y;
        ALU_ctl = 4'b0001;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Edges until done is seen, bounded at 40
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 40);
    endtask

    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] er, input logic ez,
                          input logic eo);
        int lat;
        start_op(c, x, y);
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'd33);
        check({tag, "_result"}, result, er);
        check({tag, "_zero"}, 32'(zero), 32'(ez));
        check({tag, "_overflow"}, 32'(overflow), 32'(eo));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int pre;
        int ndone;

        rst     = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        ALU_ctl = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_zero", 32'(zero), 32'd1);
        check("reset_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_small", 4'b0010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0);
        // done must be a single-cycle pulse
        @(posedge clk);
        #1;
        check("done_pulse_width", 32'(done), 32'd0);

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op("slt_neg", 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("slt_eq",  4'b0111, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0);
        run_op("and",     4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0);
        run_op("or",      4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0);
        run_op("nor",     4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0);

        // start pulsed mid-RUN is ignored; outputs hold the previous value
        start_op(4'b0010, 32'h0000_0010, 32'h0000_0020);
        pre = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            pre++;
        end
        check("midrun_result_hold", result, 32'h000F_000F);
        check("midrun_busy", 32'(busy), 32'd1);
        ALU_ctl = 4'b0110;
        a       = 32'hFFFF_FFFF;
        b       = 32'h1234_5678;
        start   = 1'b1;
        @(posedge clk);
        #1;
        pre++;
        start   = 1'b0;
        wait_done(lat);
        check("midrun_latency", 32'(pre + lat), 32'd33);
        check("midrun_result", result, 32'h0000_0030);

        // start in the done cycle is accepted immediately
        start_op(4'b0110, 32'h0000_0100, 32'h0000_0001);
        wait_done(lat);
        check("b2b_latency", 32'(lat), 32'd33);
        check("b2b_result", result, 32'h0000_00FF);

        run_op("invalid", 4'b0011, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
        run_op("add_pre_rst", 4'b0010, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);

        // asynchronous reset at bit 10 of a SUB
        start_op(4'b0110, 32'h1234_5678, 32'h0000_0001);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_zero", 32'(zero), 32'd1);
        check("rst_mid_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("rst_no_done", 32'(ndone), 32'd0);
        check("rst_idle_busy", 32'(busy), 32'd0);

        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
